// File: rtl/parity_sched_pkg.sv
// ----------------------------------------------------------------------------
// parity_sched_pkg
//
// Shared definitions for the parity frame scheduler:
//   sched_state_t : scheduler FSM encoding (IDLE, LOAD, SHIFT, RESULT)
//   id_width()    : width of a requester index, never less than one bit so a
//                   single-requester build still has a legal res_id port
// ----------------------------------------------------------------------------
package parity_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        SHIFT  = 2'd2,
        RESULT = 2'd3
    } sched_state_t;

    // max(1, $clog2(n))
    function automatic int id_width(input int n);
        if (n <= 1) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
//
// Purely combinational round-robin pick: the first asserted request at or
// after ptr, searching cyclically through N requesters.
//
// Ports:
//   req       in  N   request vector
//   ptr       in  IW  index that has highest priority this round (< N)
//   grant_oh  out N   one-hot grant (all zero when no request)
//   grant_idx out IW  index of the granted requester (0 when no request)
//   any       out 1   at least one request present
// ----------------------------------------------------------------------------
module rr_arbiter
    import parity_sched_pkg::*;
#(
    parameter int  N  = 4,
    localparam int IW = id_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant_oh,
    output logic [IW-1:0] grant_idx,
    output logic          any
);

    // One extra bit so ptr + k can exceed N-1 before it is folded back.
    logic [IW:0]   pos;
    logic [IW-1:0] idx;
    logic          found;

    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        found     = 1'b0;
        pos       = '0;
        idx       = '0;
        for (int k = 0; k < N; k++) begin
            pos = {1'b0, ptr} + (IW+1)'(k);
            if (pos >= (IW+1)'(N)) begin
                pos = pos - (IW+1)'(N);
            end
            idx = pos[IW-1:0];
            if (!found && req[idx]) begin
                found         = 1'b1;
                grant_idx     = idx;
                grant_oh[idx] = 1'b1;
            end
        end
        any = found;
    end

endmodule

// File: rtl/parity_frame_scheduler.sv
// ----------------------------------------------------------------------------
// parity_frame_scheduler
//
// Shares one bit-serial parity engine between NUM_REQ requesters. A requester
// is granted round-robin and keeps the grant for its whole frame; every word
// is shifted through the accumulator one bit per cycle, and one parity result
// per frame is returned tagged with the owning requester id.
//
// Ports:
//   clk         in  1               rising-edge clock
//   rst         in  1               synchronous active-high reset
//   req_valid   in  NUM_REQ         per-requester word valid
//   req_data    in  NUM_REQ*DATA_W  requester i word at [i*DATA_W +: DATA_W]
//   req_last    in  NUM_REQ         word closes the frame
//   req_ready   out NUM_REQ         one-hot word accept (LOAD state only)
//   res_valid   out 1               frame result available (registered)
//   res_parity  out 1               frame parity, XOR of all bits ^ ODD
//   res_id      out IDW             requester that owned the frame
//   res_ready   in  1               result consumer accept
//   busy        out 1               FSM not in IDLE (registered)
//
// Handshakes: a word moves on a rising edge where req_valid[i] and
// req_ready[i] are both high; a result moves on an edge where res_valid and
// res_ready are both high. Data is ignored in every other cycle, and the
// valids of non-granted requesters are ignored until the frame's result has
// been taken.
// ----------------------------------------------------------------------------
module parity_frame_scheduler
    import parity_sched_pkg::*;
#(
    parameter int  NUM_REQ = 4,
    parameter int  DATA_W  = 8,
    parameter int  ODD     = 0,
    localparam int IDW     = id_width(NUM_REQ)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    input  logic [NUM_REQ-1:0]          req_last,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        res_valid,
    output logic                        res_parity,
    output logic [IDW-1:0]              res_id,
    input  logic                        res_ready,
    output logic                        busy
);

    localparam int             CW       = $clog2(DATA_W);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DATA_W - 1);
    localparam logic           ODD_BIT  = (ODD != 0);
    localparam logic [IDW-1:0] LAST_ID  = IDW'(NUM_REQ - 1);

    sched_state_t         state;
    logic [IDW-1:0]       grant;
    logic [NUM_REQ-1:0]   grant_oh_q;
    logic [IDW-1:0]       rr_ptr;
    logic [IDW-1:0]       next_ptr;
    logic [DATA_W-1:0]    sreg;
    logic [CW-1:0]        cnt;
    logic                 acc;
    logic                 last_q;

    logic [NUM_REQ-1:0]   arb_oh;
    logic [IDW-1:0]       arb_idx;
    logic                 arb_any;

    logic [DATA_W-1:0]    word_sel;
    logic                 last_sel;
    logic                 valid_sel;

    // ------------------------------------------------------------------
    // Arbitration: only consulted in IDLE, the result is latched into
    // grant / grant_oh_q so the frame owner cannot change mid-frame.
    // ------------------------------------------------------------------
    rr_arbiter #(
        .N (NUM_REQ)
    ) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant_oh  (arb_oh),
        .grant_idx (arb_idx),
        .any       (arb_any)
    );

    // ------------------------------------------------------------------
    // Select the granted requester's word, last flag and valid.
    // ------------------------------------------------------------------
    always_comb begin
        word_sel  = '0;
        last_sel  = 1'b0;
        valid_sel = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant == IDW'(i)) begin
                word_sel  = req_data[i*DATA_W +: DATA_W];
                last_sel  = req_last[i];
                valid_sel = req_valid[i];
            end
        end
    end

    // The frame owner drops to lowest priority for the next round.
    assign next_ptr = (grant == LAST_ID) ? '0 : grant + 1'b1;

    // Word accept is offered only while waiting for a word of the frame.
    assign req_ready = (state == LOAD) ? grant_oh_q : '0;

    // ------------------------------------------------------------------
    // Scheduler FSM with registered result/busy outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= '0;
            grant_oh_q <= '0;
            rr_ptr     <= '0;
            sreg       <= '0;
            cnt        <= '0;
            acc        <= 1'b0;
            last_q     <= 1'b0;
            res_valid  <= 1'b0;
            res_parity <= 1'b0;
            res_id     <= '0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_any) begin
                        grant      <= arb_idx;
                        grant_oh_q <= arb_oh;
                        busy       <= 1'b1;
                        state      <= LOAD;
                    end
                end

                LOAD: begin
                    // No timeout: a stalled owner keeps the engine.
                    if (valid_sel) begin
                        sreg   <= word_sel;
                        last_q <= last_sel;
                        cnt    <= '0;
                        state  <= SHIFT;
                    end
                end

                SHIFT: begin
                    acc  <= acc ^ sreg[0];
                    sreg <= sreg >> 1;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        if (last_q) begin
                            // acc has not yet absorbed this cycle's bit,
                            // so fold it in for the registered result.
                            res_valid  <= 1'b1;
                            res_parity <= acc ^ sreg[0] ^ ODD_BIT;
                            res_id     <= grant;
                            state      <= RESULT;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end

                RESULT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        acc       <= 1'b0;
                        rr_ptr    <= next_ptr;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_parity_frame_scheduler.sv
// ----------------------------------------------------------------------------
// tb_parity_frame_scheduler
//
// Drives an even-parity and an odd-parity scheduler with identical stimulus.
// Expected {id, parity} pairs are queued as frames are driven and popped as
// results appear.
// ----------------------------------------------------------------------------
module tb_parity_frame_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic        res_ready;

    logic [3:0]  req_ready;
    logic        res_valid;
    logic        res_parity;
    logic [1:0]  res_id;
    logic        busy;

    logic [3:0]  req_ready_o;
    logic        res_valid_o;
    logic        res_parity_o;
    logic [1:0]  res_id_o;
    logic        busy_o;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          res_count = 0;

    logic [2:0]  exp_q[$];
    logic [2:0]  exp_e;
    logic [2:0]  got;

    parity_frame_scheduler #(.NUM_REQ(4), .DATA_W(8), .ODD(0)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .res_valid(res_valid),
        .res_parity(res_parity), .res_id(res_id), .res_ready(res_ready),
        .busy(busy)
    );

    parity_frame_scheduler #(.NUM_REQ(4), .DATA_W(8), .ODD(1)) dut_odd (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready_o), .res_valid(res_valid_o),
        .res_parity(res_parity_o), .res_id(res_id_o), .res_ready(res_ready),
        .busy(busy_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (res_valid && res_ready) res_count <= res_count + 1;
    end

    initial begin
        #300000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    task step;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task apply_reset;
        rst = 1'b1;
        step;
        step;
        rst = 1'b0;
    endtask

    // ---------------- drivers ----------------
    task set_word(input int idx, input logic [7:0] d, input logic l);
        req_valid[idx]       = 1'b1;
        req_data[idx*8 +: 8] = d;
        req_last[idx]        = l;
    endtask

    // Presents one word and returns right after the edge that accepted it;
    // rdy_cyc is the cycle in which req_ready was seen high.
    task put_word(input int idx, input logic [7:0] d, input logic l, output int rdy_cyc);
        set_word(idx, d, l);
        for (int t = 0; t < 100 && req_ready[idx] !== 1'b1; t++) step;
        checks++;
        if (req_ready[idx] !== 1'b1) begin
            errors++;
            $display("FAIL put_word_timeout req=%0d ready=%b exp ready[%0d]=1", idx, req_ready, idx);
            rdy_cyc = -1;
        end else begin
            rdy_cyc = cyc;
            step;
        end
        req_valid[idx] = 1'b0;
    endtask

    task wait_res(output bit ok);
        for (int t = 0; t < 200 && res_valid !== 1'b1; t++) step;
        ok = (res_valid === 1'b1);
    endtask

    // ---------------- tests ----------------
    task test_reset;
        rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0; res_ready = 1'b0;
        step;
        step;
        rst = 1'b0;
        got = {res_valid, res_parity, busy};
        checks++;
        if (got !== 3'b000 || req_ready !== 4'b0000 || res_id !== 2'd0) begin
            errors++;
            $display("FAIL reset_outputs got vld/par/busy=%b ready=%b id=%0d exp 000/0000/0", got, req_ready, res_id);
        end
        checks++;
        if (req_ready_o !== 4'b0000 || res_valid_o !== 1'b0 || busy_o !== 1'b0 || res_id_o !== 2'd0 || res_parity_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs_odd ready=%b vld=%b busy=%b exp 0", req_ready_o, res_valid_o, busy_o);
        end
        step;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_busy got %b exp 0", busy);
        end
    endtask

    task test_single_word;
        logic [3:0] exp_rdy;
        bit ok;
        res_ready = 1'b1;
        set_word(0, 8'h07, 1'b1);
        exp_q.push_back({2'd0, 1'b1});
        for (int n = 0; n <= 10; n++) begin
            if (n > 0) step;
            if (n == 2) req_valid[0] = 1'b0;
            exp_rdy = (n == 1) ? 4'b0001 : 4'b0000;
            checks++;
            if (req_ready !== exp_rdy) begin
                errors++;
                $display("FAIL single_ready cycle %0d got %b exp %b", n, req_ready, exp_rdy);
            end
            checks++;
            if (res_valid !== (n == 10)) begin
                errors++;
                $display("FAIL single_res_valid cycle %0d got %b exp %b", n, res_valid, (n == 10));
            end
        end
        ok = (res_valid === 1'b1);
        if (ok && exp_q.size() > 0) begin
            exp_e = exp_q.pop_front();
            got   = {res_id, res_parity};
            checks++;
            if (got !== exp_e || res_parity_o !== ~exp_e[0]) begin
                errors++;
                $display("FAIL single_result got id/par %h odd_par %b exp %h", got, res_parity_o, exp_e);
            end
        end
        step;
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_after_hs vld=%b busy=%b exp 0 0", res_valid, busy);
        end
    endtask

    task test_multi_word;
        int a1, a2, rc0;
        bit ok;
        res_ready = 1'b1;
        rc0 = res_count;
        exp_q.push_back({2'd2, 1'b1});
        put_word(2, 8'h03, 1'b0, a1);
        put_word(2, 8'h01, 1'b1, a2);
        checks++;
        if (a2 - a1 != 9) begin
            errors++;
            $display("FAIL multi_word_gap got %0d exp 9", a2 - a1);
        end
        checks++;
        if (res_count != rc0) begin
            errors++;
            $display("FAIL multi_early_result got %0d results exp %0d", res_count - rc0, 0);
        end
        wait_res(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL multi_timeout res_valid=%b exp 1", res_valid);
        end else begin
            exp_e = exp_q.pop_front();
            got   = {res_id, res_parity};
            if (got !== exp_e || res_parity_o !== ~exp_e[0]) begin
                errors++;
                $display("FAIL multi_result got %h odd_par %b exp %h", got, res_parity_o, exp_e);
            end
        end
        step;
    endtask

    task test_round_robin;
        bit ok;
        apply_reset;
        res_ready = 1'b1;
        exp_q.push_back({2'd0, 1'b0});
        exp_q.push_back({2'd1, 1'b1});
        exp_q.push_back({2'd2, 1'b0});
        exp_q.push_back({2'd3, 1'b0});
        exp_q.push_back({2'd0, 1'b0});
        set_word(0, 8'h00, 1'b1);
        set_word(1, 8'h01, 1'b1);
        set_word(2, 8'h03, 1'b1);
        set_word(3, 8'hFF, 1'b1);
        for (int k = 0; k < 5; k++) begin
            wait_res(ok);
            checks++;
            if (!ok || exp_q.size() == 0) begin
                errors++;
                $display("FAIL rr_timeout frame %0d res_valid=%b exp 1", k, res_valid);
            end else begin
                exp_e = exp_q.pop_front();
                got   = {res_id, res_parity};
                if (got !== exp_e || res_parity_o !== ~exp_e[0] || res_id_o !== exp_e[2:1]) begin
                    errors++;
                    $display("FAIL rr_result frame %0d got %h odd_par %b exp %h", k, got, res_parity_o, exp_e);
                end
            end
            if (k == 4) req_valid = '0;
            step;
        end
    endtask

    task test_backpressure;
        int a, rc0;
        bit ok;
        res_ready = 1'b0;
        exp_q.push_back({2'd1, 1'b0});
        put_word(1, 8'h05, 1'b1, a);
        wait_res(ok);
        set_word(3, 8'h0F, 1'b1);
        rc0 = res_count;
        for (int k = 0; k < 5; k++) begin
            step;
            checks++;
            if (res_valid !== 1'b1 || {res_id, res_parity} !== exp_q[0]) begin
                errors++;
                $display("FAIL hold_result cycle %0d vld=%b got %h exp 1 %h", k, res_valid, {res_id, res_parity}, exp_q[0]);
            end
            checks++;
            if (req_ready !== 4'b0000 || busy !== 1'b1) begin
                errors++;
                $display("FAIL hold_ready_busy cycle %0d ready=%b busy=%b exp 0000 1", k, req_ready, busy);
            end
        end
        req_valid[3] = 1'b0;
        res_ready    = 1'b1;
        exp_e = exp_q.pop_front();
        step;
        checks++;
        if (res_valid !== 1'b0 || res_count != rc0 + 1) begin
            errors++;
            $display("FAIL hold_transfer vld=%b transfers=%0d exp 0 1", res_valid, res_count - rc0);
        end
    endtask

    task test_reset_mid_shift;
        int a, c0, rc0;
        bit ok;
        res_ready = 1'b1;
        put_word(2, 8'hFF, 1'b1, a);
        step;
        step;
        step;
        rst = 1'b1;
        step;
        rst = 1'b0;
        checks++;
        if (req_ready !== 4'b0000 || res_valid !== 1'b0 || res_parity !== 1'b0 || res_id !== 2'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs ready=%b vld=%b par=%b id=%0d busy=%b exp all 0",
                     req_ready, res_valid, res_parity, res_id, busy);
        end
        rc0 = res_count;
        c0  = cyc;
        exp_q.push_back({2'd3, 1'b0});
        put_word(3, 8'h00, 1'b1, a);
        checks++;
        if (a - c0 != 1) begin
            errors++;
            $display("FAIL midreset_grant_latency got %0d exp 1", a - c0);
        end
        wait_res(ok);
        checks++;
        if (!ok || res_count != rc0) begin
            errors++;
            $display("FAIL midreset_stale vld=%b transfers=%0d exp 1 0", res_valid, res_count - rc0);
        end else begin
            exp_e = exp_q.pop_front();
            got   = {res_id, res_parity};
            if (got !== exp_e) begin
                errors++;
                $display("FAIL midreset_result got %h exp %h", got, exp_e);
            end
        end
        step;
    endtask

    task test_odd_and_stall;
        int a;
        bit ok;
        res_ready = 1'b1;
        // Zero word: even engine gives 0, odd engine gives 1.
        exp_q.push_back({2'd2, 1'b0});
        put_word(2, 8'h00, 1'b1, a);
        wait_res(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL odd_timeout res_valid=%b exp 1", res_valid);
        end else begin
            exp_e = exp_q.pop_front();
            if ({res_id, res_parity} !== exp_e || res_parity_o !== 1'b1) begin
                errors++;
                $display("FAIL odd_zero got %h odd_par %b exp %h odd_par 1", {res_id, res_parity}, res_parity_o, exp_e);
            end
        end
        step;
        // Requester 1 stalls mid-frame while requester 0 waits.
        exp_q.push_back({2'd1, 1'b0});
        exp_q.push_back({2'd0, 1'b1});
        put_word(1, 8'h01, 1'b0, a);
        set_word(0, 8'h80, 1'b1);
        for (int t = 0; t < 50 && req_ready !== 4'b0010; t++) step;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (req_ready !== 4'b0010 || busy !== 1'b1 || res_valid !== 1'b0) begin
                errors++;
                $display("FAIL stall_grant cycle %0d ready=%b busy=%b vld=%b exp 0010 1 0", k, req_ready, busy, res_valid);
            end
            step;
        end
        put_word(1, 8'h02, 1'b1, a);
        for (int f = 0; f < 2; f++) begin
            wait_res(ok);
            checks++;
            if (!ok || exp_q.size() == 0) begin
                errors++;
                $display("FAIL stall_timeout frame %0d res_valid=%b exp 1", f, res_valid);
            end else begin
                exp_e = exp_q.pop_front();
                got   = {res_id, res_parity};
                if (got !== exp_e || res_parity_o !== ~exp_e[0]) begin
                    errors++;
                    $display("FAIL stall_result frame %0d got %h odd_par %b exp %h", f, got, res_parity_o, exp_e);
                end
            end
            if (f == 1) req_valid[0] = 1'b0;
            step;
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset;
        test_single_word;
        test_multi_word;
        test_round_robin;
        test_backpressure;
        test_reset_mid_shift;
        test_odd_and_stall;
        step;
        checks++;
        if (exp_q.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL end_state pending=%0d busy=%b exp 0 0", exp_q.size(), busy);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/parity_frame_scheduler.md
Name: parity_frame_scheduler

Overview:
Shares one serial parity engine between NUM_REQ requesters. Each requester sends a frame of one or more DATA_W-bit words over a valid/ready handshake. The block grants requesters round-robin, locks the grant for a whole frame, and shifts each word through the parity accumulator one bit per cycle. It returns one parity result per frame, tagged with the requester id, over a valid/ready result port. It sits in front of the byte-parity datapath and is the only path into it.

Parameters:
NUM_REQ, 4, number of requesters (1..16)
DATA_W, 8, word width in bits (2..32)
ODD, 0, 0 = even parity (XOR of all bits); 1 = odd parity (XOR inverted)

Ports:
clk  in  1  single clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  per-requester word valid
req_data  in  NUM_REQ*DATA_W  packed words, requester i at [i*DATA_W +: DATA_W]
req_last  in  NUM_REQ  word is the final word of the frame
req_ready  out  NUM_REQ  one-hot word accept; at most one bit set
res_valid  out  1  frame result available
res_parity  out  1  frame parity
res_id  out  $clog2(NUM_REQ) (min 1)  requester that owned the frame
res_ready  in  1  result consumer accept
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: takes effect on the next clock edge and sets:
  - state=IDLE; req_ready=0; res_valid=0; res_parity=0; res_id=0; busy=0
  - accumulator=0; shift register=0; bit counter=0; rr_ptr=0
  - Reset during any state discards the frame in progress. No result is emitted for it.
- FSM states:
  - IDLE:
    - If any req_valid is high, latch grant = first valid index at or after rr_ptr, searching cyclically. Go to LOAD.
    - Otherwise stay in IDLE.
  - LOAD:
    - req_ready[grant]=1 combinationally; all other req_ready bits are 0.
    - If req_valid[grant]=1: capture req_data word and req_last; clear bit counter; go to SHIFT.
    - Otherwise stay in LOAD. There is no timeout, and a mid-frame stall keeps the grant locked.
  - SHIFT:
    - Each cycle: acc ^= sreg[0]; sreg >>= 1; cnt++.
    - When cnt == DATA_W-1, the cycle completes the word. Go to RESULT if last_q is set, otherwise go to LOAD.
  - RESULT:
    - res_valid=1, res_parity=acc^ODD, res_id=grant. Outputs are registered and held stable while res_ready=0.
    - When res_ready=1: go to IDLE, set rr_ptr=(grant+1) mod NUM_REQ, clear acc.
- Latency (cycle 0 = IDLE sees a request):
  - Grant in cycle 0, word accepted in cycle 1, SHIFT in cycles 2..DATA_W+1.
  - res_valid rises at cycle DATA_W+2 (cycle 10 for DATA_W=8) when req_valid is held.
  - Each additional word adds 1+DATA_W cycles.
- Handshakes:
  - A word transfers only when req_valid[i] and req_ready[i] are both high in the same cycle.
  - req_data is ignored in every other cycle.
  - req_valid of non-granted requesters is ignored until the frame ends.
  - A result transfers only when res_valid and res_ready are both high.
- Boundary conditions:
  - Simultaneous requests are resolved purely by rr_ptr.
  - A requester that is still valid after its frame gets lowest priority next round.
  - rr_ptr wraps from NUM_REQ-1 to 0.
  - NUM_REQ=1 degenerates to a fixed grant of 0.
  - The block does not pipeline: no new grant is issued until the result handshake completes.

Decomposition:
- Package parity_sched_pkg holds:
  - typedef enum logic [1:0] {IDLE, LOAD, SHIFT, RESULT} sched_state_t
  - helper function for the id width: max(1, $clog2(n))
- Sub-module rr_arbiter (parameter N):
  - Inputs: req vector, ptr.
  - Outputs: one-hot grant, grant index, any.
  - Purely combinational, instantiated once.
  - The FSM, shift register and accumulator stay in the top module.

Test Plan:
1. Requester 0 sends single word 0x07 with last=1, res_ready=1 -> res_valid rises at cycle 10; res_parity=1, res_id=0; req_ready[0] is high only in cycle 1.
2. Requester 2 sends frame 0x03, 0x01(last) -> one result, res_parity=1, res_id=2. Second word accepted 9 cycles after the first; no result between the words.
3. All four requesters continuously valid with single-word frames 0x00, 0x01, 0x03, 0xFF -> grant order 0,1,2,3,0; parities 0,1,0,0.
4. res_ready held low for 5 cycles in RESULT -> res_valid, res_parity and res_id stay stable; all req_ready=0; busy=1; transfer occurs on the cycle res_ready rises.
5. rst pulsed for 1 cycle mid-SHIFT -> next cycle all outputs are 0 and the state is IDLE. A new request from requester 3 is granted, confirming rr_ptr=0 semantics (index 3 is first valid). No stale result is emitted.
6. ODD=1, word 0x00 -> res_parity=1. Requester 1 stalls in LOAD (valid low 4 cycles mid-frame) -> the grant is kept, and requester 0's valid is ignored until the frame completes.
